// File: rtl/ccw_rx_pkg.sv
// Shared definitions for the HSI command-control-word receiver: default frame
// length, timeout default and FSM state encodings.
package ccw_rx_pkg;

  localparam int CCW_LEN         = 8;
  localparam int CCW_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    CCWR_STATE_IDLE = 2'd0,
    CCWR_STATE_DATA = 2'd1,
    CCWR_STATE_HOLD = 2'd2
  } ccwr_state_e;

endpackage

// File: rtl/ccw_rx_buf.sv
// Payload register file for ccw_rx: DEPTH x 8 bits, one synchronous write port
// and one combinational read port that returns 0 for addresses beyond DEPTH.
module ccw_rx_buf #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];

  // Contents are deliberately not reset; only written bytes are ever read back.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == 8'(i))) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == 8'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/ccw_rx.sv
// Receiver for length-prefixed CCW frames from the HSI byte deserialiser.
// Define CCW_RX_TIMEOUT_EN to abort a frame whose bytes stop arriving.
module ccw_rx
  import ccw_rx_pkg::*;
#(
  parameter int CCW_MAX_LEN = CCW_LEN,
  parameter int TIMEOUT_CYC = CCW_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_d,
  input  logic       rx_d_vld,
  output logic       ccw_accepted,
  output logic       ccw_repeat_req,
  output logic       ccw_overrun,
  output logic       ccw_busy,
  output logic [7:0] ccw_len,
  input  logic [7:0] ccw_rd_addr,
  output logic [7:0] ccw_rd_data,
  input  logic       ccw_release
);

  localparam logic [7:0] MAX_LEN8 = 8'(CCW_MAX_LEN);

  ccwr_state_e state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  len_nxt;
  logic        acc_nxt, rep_nxt, ovr_nxt;
  logic        buf_we;
  logic        timeout_hit;

`ifdef CCW_RX_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_hit = (idle_cnt == 16'(TIMEOUT_CYC - 1));

  // Only a silent DATA phase advances the counter; any other case restarts it.
  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (state == CCWR_STATE_DATA && !rx_d_vld && !timeout_hit)
      idle_cnt <= idle_cnt + 16'd1;
    else
      idle_cnt <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CCWR_STATE_IDLE;
      cnt            <= '0;
      ccw_len        <= '0;
      ccw_accepted   <= 1'b0;
      ccw_repeat_req <= 1'b0;
      ccw_overrun    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ccw_len        <= len_nxt;
      ccw_accepted   <= acc_nxt;
      ccw_repeat_req <= rep_nxt;
      ccw_overrun    <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = ccw_len;
    acc_nxt   = 1'b0;
    rep_nxt   = 1'b0;
    ovr_nxt   = 1'b0;
    buf_we    = 1'b0;
    case (state)
      CCWR_STATE_IDLE: begin
        if (rx_d_vld) begin
          if (rx_d == 8'd0 || rx_d > MAX_LEN8) begin
            rep_nxt = 1'b1;
          end else begin
            len_nxt   = rx_d;
            cnt_nxt   = '0;
            state_nxt = CCWR_STATE_DATA;
          end
        end
      end
      CCWR_STATE_DATA: begin
        if (rx_d_vld) begin
          buf_we  = 1'b1;
          cnt_nxt = cnt + 8'd1;
          if (cnt == ccw_len - 8'd1) begin
            state_nxt = CCWR_STATE_HOLD;
            acc_nxt   = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt = CCWR_STATE_IDLE;
          cnt_nxt   = '0;
          rep_nxt   = 1'b1;
        end
      end
      CCWR_STATE_HOLD: begin
        // A byte arriving with release is still an overrun, never a new length.
        if (rx_d_vld)    ovr_nxt   = 1'b1;
        if (ccw_release) state_nxt = CCWR_STATE_IDLE;
      end
      default: state_nxt = CCWR_STATE_IDLE;
    endcase
  end

  assign ccw_busy = (state != CCWR_STATE_IDLE);

  ccw_rx_buf #(
    .DEPTH(CCW_MAX_LEN)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(cnt),
    .wdata(rx_d),
    .raddr(ccw_rd_addr),
    .rdata(ccw_rd_data)
  );

endmodule

// File: tb/tb_ccw_rx.sv
// Directed self-checking bench for ccw_rx (CCW_MAX_LEN=8, TIMEOUT_CYC=16).
module tb_ccw_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_d;
  logic       rx_d_vld;
  logic       ccw_accepted;
  logic       ccw_repeat_req;
  logic       ccw_overrun;
  logic       ccw_busy;
  logic [7:0] ccw_len;
  logic [7:0] ccw_rd_addr;
  logic [7:0] ccw_rd_data;
  logic       ccw_release;

  int checks   = 0;
  int failures = 0;

  ccw_rx #(
    .CCW_MAX_LEN(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_d          (rx_d),
    .rx_d_vld      (rx_d_vld),
    .ccw_accepted  (ccw_accepted),
    .ccw_repeat_req(ccw_repeat_req),
    .ccw_overrun   (ccw_overrun),
    .ccw_busy      (ccw_busy),
    .ccw_len       (ccw_len),
    .ccw_rd_addr   (ccw_rd_addr),
    .ccw_rd_data   (ccw_rd_data),
    .ccw_release   (ccw_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobes one byte for a single cycle; returns at the negedge after capture.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_d     = b;
    rx_d_vld = 1'b1;
    @(negedge clk);
    rx_d_vld = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    ccw_rd_addr = addr;
    #1;
    check(tag, ccw_rd_data, exp);
  endtask

  task automatic release_frame();
    @(negedge clk);
    ccw_release = 1'b1;
    @(negedge clk);
    ccw_release = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rx_d        = 8'h00;
    rx_d_vld    = 1'b0;
    ccw_rd_addr = 8'h00;
    ccw_release = 1'b0;
    wait_cycles(2);
    check("reset_busy", 8'(ccw_busy), 8'h00);
    check("reset_len", ccw_len, 8'h00);
    check("reset_acc", 8'(ccw_accepted), 8'h00);
    check("reset_rep", 8'(ccw_repeat_req), 8'h00);
    check("reset_ovr", 8'(ccw_overrun), 8'h00);
    rst = 1'b0;

    // Test 1: length 3, payload A1 A2 A3 at one strobe every 2 cycles
    send_byte(8'd3);
    check("t1_busy_data", 8'(ccw_busy), 8'h01);
    wait_cycles(1);
    send_byte(8'hA1);
    check("t1_acc_early", 8'(ccw_accepted), 8'h00);
    wait_cycles(1);
    send_byte(8'hA2);
    wait_cycles(1);
    send_byte(8'hA3);
    check("t1_acc", 8'(ccw_accepted), 8'h01);
    check("t1_len", ccw_len, 8'd3);
    check("t1_busy_hold", 8'(ccw_busy), 8'h01);
    wait_cycles(1);
    check("t1_acc_1cyc", 8'(ccw_accepted), 8'h00);
    read_check("t1_rd0", 8'd0, 8'hA1);
    read_check("t1_rd1", 8'd1, 8'hA2);
    read_check("t1_rd2", 8'd2, 8'hA3);
    read_check("t1_rd_oob", 8'd9, 8'h00);

    // Test 3: bytes during HOLD are overruns and leave the buffer alone
    send_byte(8'h55);
    check("t3_ovr1", 8'(ccw_overrun), 8'h01);
    send_byte(8'h66);
    check("t3_ovr2", 8'(ccw_overrun), 8'h01);
    check("t3_len_kept", ccw_len, 8'd3);
    read_check("t3_rd0", 8'd0, 8'hA1);
    read_check("t3_rd2", 8'd2, 8'hA3);
    release_frame();
    check("t3_busy_rel", 8'(ccw_busy), 8'h00);
    check("t3_ovr_clr", 8'(ccw_overrun), 8'h00);

    // Test 2: illegal length bytes 0 and CCW_MAX_LEN+1
    send_byte(8'd0);
    check("t2_rep_zero", 8'(ccw_repeat_req), 8'h01);
    check("t2_busy_zero", 8'(ccw_busy), 8'h00);
    send_byte(8'd9);
    check("t2_rep_big", 8'(ccw_repeat_req), 8'h01);
    check("t2_busy_big", 8'(ccw_busy), 8'h00);
    wait_cycles(1);
    check("t2_rep_1cyc", 8'(ccw_repeat_req), 8'h00);
    send_byte(8'd8);
    check("t2_max_ok", 8'(ccw_busy), 8'h01);
    check("t2_max_norep", 8'(ccw_repeat_req), 8'h00);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;

    // Test 4: release and strobe in the same cycle
    send_byte(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    check("t4_acc", 8'(ccw_accepted), 8'h01);
    @(negedge clk);
    ccw_release = 1'b1;
    rx_d        = 8'h02;
    rx_d_vld    = 1'b1;
    @(negedge clk);
    ccw_release = 1'b0;
    rx_d_vld    = 1'b0;
    check("t4_ovr", 8'(ccw_overrun), 8'h01);
    check("t4_busy_idle", 8'(ccw_busy), 8'h00);
    send_byte(8'h02);
    check("t4_new_frame", 8'(ccw_busy), 8'h01);
    check("t4_norep", 8'(ccw_repeat_req), 8'h00);
    send_byte(8'h33);
    send_byte(8'h44);
    check("t4_acc2", 8'(ccw_accepted), 8'h01);
    check("t4_len2", ccw_len, 8'd2);
    read_check("t4_rd0", 8'd0, 8'h33);
    read_check("t4_rd1", 8'd1, 8'h44);
    release_frame();

    // Test 5: reset mid-frame, then a one-byte frame
    send_byte(8'd4);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_rst", 8'(ccw_busy), 8'h00);
    check("t5_len_rst", ccw_len, 8'h00);
    send_byte(8'd1);
    send_byte(8'h5A);
    check("t5_acc", 8'(ccw_accepted), 8'h01);
    check("t5_len", ccw_len, 8'd1);
    read_check("t5_rd0", 8'd0, 8'h5A);
    release_frame();

    // Test 6: silence in DATA
    send_byte(8'd4);
    send_byte(8'h77);
`ifdef CCW_RX_TIMEOUT_EN
    wait_cycles(15);
    check("t6_rep_early", 8'(ccw_repeat_req), 8'h00);
    check("t6_busy_early", 8'(ccw_busy), 8'h01);
    wait_cycles(1);
    check("t6_rep", 8'(ccw_repeat_req), 8'h01);
    check("t6_busy_drop", 8'(ccw_busy), 8'h00);
`else
    wait_cycles(40);
    check("t6_busy_wait", 8'(ccw_busy), 8'h01);
    check("t6_norep", 8'(ccw_repeat_req), 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
